// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch / load-store / RAM signal bundle for mem_port_arbiter
//
// Groups the three buses that meet at the arbiter.
//   IF_*  : instruction-fetch request/acknowledge channel
//   D_*   : load/store request/acknowledge channel (D_ERR valid with D_ACK)
//   MEM_* : unified RAM port (strobes out, MEM_DATA_IN/MEM_READY in)
// Modports:
//   slave  : the arbiter's view (requests and RAM responses in, grants/strobes out)
//   master : the environment's view (core requesters plus RAM)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic              IF_REQ;
  logic [ADDR_W-1:0] IF_ADDR;
  logic [31:0]       IF_RDATA;
  logic              IF_ACK;

  logic              D_REQ;
  logic              D_WE;
  logic [ADDR_W-1:0] D_ADDR;
  logic [31:0]       D_WDATA;
  logic [3:0]        D_BE;
  logic [31:0]       D_RDATA;
  logic              D_ACK;
  logic              D_ERR;

  logic [ADDR_W-1:0] MEM_ADDR;
  logic [31:0]       MEM_DATA_OUT;
  logic [31:0]       MEM_DATA_IN;
  logic [3:0]        MEM_BYTE_ENABLE;
  logic              MEM_WRITE_ENABLE;
  logic              MEM_READ_ENABLE;
  logic              MEM_READY;

  modport slave (
    input  IF_REQ, IF_ADDR,
    input  D_REQ, D_WE, D_ADDR, D_WDATA, D_BE,
    input  MEM_DATA_IN, MEM_READY,
    output IF_RDATA, IF_ACK,
    output D_RDATA, D_ACK, D_ERR,
    output MEM_ADDR, MEM_DATA_OUT, MEM_BYTE_ENABLE, MEM_WRITE_ENABLE, MEM_READ_ENABLE
  );

  modport master (
    output IF_REQ, IF_ADDR,
    output D_REQ, D_WE, D_ADDR, D_WDATA, D_BE,
    output MEM_DATA_IN, MEM_READY,
    input  IF_RDATA, IF_ACK,
    input  D_RDATA, D_ACK, D_ERR,
    input  MEM_ADDR, MEM_DATA_OUT, MEM_BYTE_ENABLE, MEM_WRITE_ENABLE, MEM_READ_ENABLE
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-master arbiter for the unified RAM port (fetch vs load/store)
//
// Load/store has fixed priority; a saturating starvation counter forces a
// fetch grant after STARVE_MAX consecutive data grants made while fetch waits.
// Every access is IDLE -> BUSY_x -> RESP -> IDLE (one access per 3 cycles
// with a zero-wait RAM).
//
// Ports:
//   clk    : system clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave (IF_*, D_*, MEM_* signals)
// Parameters:
//   STARVE_MAX : data grants tolerated while fetch waits (1..15)
//   ADDR_W     : address width
// Build option:
//   MISALIGN_CHECK_EN : when defined, misaligned load/store accesses are
//                       rejected with D_ACK+D_ERR and never reach the RAM.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_D  = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]        state;
  logic [3:0]        starve_cnt;

  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_be_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic [31:0]       if_rdata_q;
  logic              if_ack_q;
  logic [31:0]       d_rdata_q;
  logic              d_ack_q;

  logic              force_if;
  logic              grant_d;
  logic              grant_if;
  logic              d_illegal;

  // Fetch wins a tie only once the data side has used up its allowance.
  assign force_if = bus.IF_REQ && (starve_cnt == STARVE_LIM);
  assign grant_d  = bus.D_REQ && !force_if;
  assign grant_if = bus.IF_REQ && !grant_d;

`ifdef MISALIGN_CHECK_EN
  logic d_err_q;

  function automatic logic access_legal(input logic [3:0] be, input logic [1:0] ofs);
    logic byte_ok;
    logic half_ok;
    logic word_ok;
    byte_ok = (be == (4'b0001 << ofs));
    half_ok = (be == (4'b0011 << ofs)) && !ofs[0];
    word_ok = (be == 4'b1111) && (ofs == 2'b00);
    return byte_ok || half_ok || word_ok;
  endfunction

  assign d_illegal = !access_legal(bus.D_BE, bus.D_ADDR[1:0]);
  assign bus.D_ERR = d_err_q;
`else
  assign d_illegal = 1'b0;
  assign bus.D_ERR = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      starve_cnt  <= 4'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      if_rdata_q  <= 32'd0;
      if_ack_q    <= 1'b0;
      d_rdata_q   <= 32'd0;
      d_ack_q     <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      d_err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_if) begin
            mem_addr_q <= bus.IF_ADDR;
            mem_be_q   <= 4'b1111;
            mem_re_q   <= 1'b1;
            mem_we_q   <= 1'b0;
            starve_cnt <= 4'd0;
            state      <= ST_BUSY_IF;
          end else if (grant_d) begin
            // Only data grants that overtake a waiting fetch count as starvation.
            if (bus.IF_REQ && (starve_cnt != 4'hF)) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
            if (d_illegal) begin
              // Rejected access: acknowledge with error, RAM never sees it.
              d_ack_q <= 1'b1;
`ifdef MISALIGN_CHECK_EN
              d_err_q <= 1'b1;
`endif
              state   <= ST_RESP;
            end else begin
              mem_addr_q <= bus.D_ADDR;
              mem_be_q   <= bus.D_BE;
              mem_we_q   <= bus.D_WE;
              mem_re_q   <= !bus.D_WE;
              // MEM_DATA_OUT keeps the most recent store data across loads/fetches.
              if (bus.D_WE) begin
                mem_wdata_q <= bus.D_WDATA;
              end
              state <= ST_BUSY_D;
            end
          end
        end

        ST_BUSY_IF, ST_BUSY_D: begin
          if (bus.MEM_READY) begin
            if (state == ST_BUSY_IF) begin
              if_rdata_q <= bus.MEM_DATA_IN;
              if_ack_q   <= 1'b1;
            end else begin
              if (mem_re_q) begin
                d_rdata_q <= bus.MEM_DATA_IN;
              end
              d_ack_q <= 1'b1;
            end
            mem_be_q <= 4'd0;
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            state    <= ST_RESP;
          end
        end

        ST_RESP: begin
          // No arbitration here: gives the requester a cycle to drop REQ.
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
`ifdef MISALIGN_CHECK_EN
          d_err_q  <= 1'b0;
`endif
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.MEM_ADDR         = mem_addr_q;
  assign bus.MEM_DATA_OUT     = mem_wdata_q;
  assign bus.MEM_BYTE_ENABLE  = mem_be_q;
  assign bus.MEM_WRITE_ENABLE = mem_we_q;
  assign bus.MEM_READ_ENABLE  = mem_re_q;
  assign bus.IF_RDATA         = if_rdata_q;
  assign bus.IF_ACK           = if_ack_q;
  assign bus.D_RDATA          = d_rdata_q;
  assign bus.D_ACK            = d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int ADDR_W     = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(
    .STARVE_MAX(STARVE_MAX),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level reference state
  int          m_starve;
  logic [31:0] m_if_rdata;
  logic [31:0] m_d_rdata;
  logic [31:0] m_dout;
  int          d_run;
  int          max_run;
  bit          grant_q[$];

  // Outstanding requests held by the core model
  bit          if_pend;
  logic [31:0] if_addr;
  bit          d_pend;
  bit          d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Legal sizes: single byte anywhere, halfword on even offset, word on 0.
  function automatic bit is_legal(input logic [3:0] be, input logic [1:0] ofs);
    int n;
    n = $countones(be);
    if (n == 1) return be[ofs] == 1'b1;
    if (n == 2) return (ofs == 2'd0 && be == 4'b0011) || (ofs == 2'd2 && be == 4'b1100);
    if (n == 4) return ofs == 2'd0;
    return 1'b0;
  endfunction

  task automatic drive_reqs();
    bus.IF_REQ  = if_pend;
    bus.IF_ADDR = if_addr;
    bus.D_REQ   = d_pend;
    bus.D_WE    = d_we;
    bus.D_ADDR  = d_addr;
    bus.D_WDATA = d_wdata;
    bus.D_BE    = d_be;
  endtask

  task automatic new_fetch();
    if_pend = 1'b1;
    if_addr = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
  endtask

  task automatic new_data(input bit allow_bad);
    int kind;
    logic [31:0] r;
    r       = $urandom();
    d_pend  = 1'b1;
    d_we    = r[0];
    d_wdata = $urandom();
    d_addr  = $urandom();
    kind    = $urandom_range(0, allow_bad ? 3 : 2);
    case (kind)
      0: d_be = 4'b0001 << d_addr[1:0];
      1: begin d_addr[0] = 1'b0; d_be = d_addr[1] ? 4'b1100 : 4'b0011; end
      2: begin d_addr[1:0] = 2'b00; d_be = 4'b1111; end
      default: d_be = 4'($urandom());
    endcase
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_re"}, bus.MEM_READ_ENABLE, 0);
    chk({tag, "_we"}, bus.MEM_WRITE_ENABLE, 0);
    chk({tag, "_be"}, bus.MEM_BYTE_ENABLE, 0);
    chk({tag, "_if_ack"}, bus.IF_ACK, 0);
    chk({tag, "_d_ack"}, bus.D_ACK, 0);
    chk({tag, "_d_err"}, bus.D_ERR, 0);
  endtask

  // One arbitration starting in IDLE; w wait states on the RAM.
  task automatic do_access(input int w, input logic [31:0] rdata);
    bit          win_if;
    bit          err;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    bit          e_re;
    bit          e_we;

    drive_reqs();
    bus.MEM_DATA_IN = rdata;
    bus.MEM_READY   = (w == 0);

    if (!if_pend && !d_pend) begin
      @(posedge clk); #1;
      chk_idle_outputs("no_req");
      return;
    end

    win_if = if_pend && (!d_pend || m_starve == STARVE_MAX);
    err    = 1'b0;
`ifdef MISALIGN_CHECK_EN
    if (!win_if) err = !is_legal(d_be, d_addr[1:0]);
`endif
    if (win_if) begin
      m_starve = 0;
      d_run    = 0;
    end else if (if_pend) begin
      m_starve = (m_starve < 15) ? m_starve + 1 : 15;
      d_run++;
      if (d_run > max_run) max_run = d_run;
    end
    grant_q.push_back(win_if);

    @(posedge clk); #1;
    if (err) begin
      chk("err_ack", bus.D_ACK, 1);
      chk("err_flag", bus.D_ERR, 1);
      chk("err_no_re", bus.MEM_READ_ENABLE, 0);
      chk("err_no_we", bus.MEM_WRITE_ENABLE, 0);
      chk("err_rdata", bus.D_RDATA, m_d_rdata);
      chk("err_dout", bus.MEM_DATA_OUT, m_dout);
      d_pend = 1'b0;
      drive_reqs();
      @(posedge clk); #1;
      chk("err_resp_ack", bus.D_ACK, 0);
      chk("err_resp_flag", bus.D_ERR, 0);
      return;
    end

    if (win_if) begin
      e_addr = if_addr; e_be = 4'hF; e_re = 1'b1; e_we = 1'b0;
    end else begin
      e_addr = d_addr; e_be = d_be; e_re = !d_we; e_we = d_we;
      if (d_we) m_dout = d_wdata;
    end

    chk("grant_addr", bus.MEM_ADDR, e_addr);
    chk("grant_be", bus.MEM_BYTE_ENABLE, e_be);
    chk("grant_re", bus.MEM_READ_ENABLE, e_re);
    chk("grant_we", bus.MEM_WRITE_ENABLE, e_we);
    chk("grant_dout", bus.MEM_DATA_OUT, m_dout);
    chk("grant_no_ack", {bus.IF_ACK, bus.D_ACK}, 0);

    for (int k = 0; k < w; k++) begin
      @(posedge clk); #1;
      chk("wait_addr", bus.MEM_ADDR, e_addr);
      chk("wait_strobes", {bus.MEM_BYTE_ENABLE, bus.MEM_READ_ENABLE, bus.MEM_WRITE_ENABLE},
          {e_be, e_re, e_we});
      chk("wait_no_ack", {bus.IF_ACK, bus.D_ACK}, 0);
    end
    bus.MEM_READY = 1'b1;

    @(posedge clk); #1;
    if (win_if) m_if_rdata = rdata;
    else if (!d_we) m_d_rdata = rdata;
    chk("done_if_ack", bus.IF_ACK, win_if);
    chk("done_d_ack", bus.D_ACK, !win_if);
    chk("done_d_err", bus.D_ERR, 0);
    chk("done_strobes", {bus.MEM_BYTE_ENABLE, bus.MEM_READ_ENABLE, bus.MEM_WRITE_ENABLE}, 0);
    chk("done_if_rdata", bus.IF_RDATA, m_if_rdata);
    chk("done_d_rdata", bus.D_RDATA, m_d_rdata);

    if (win_if) if_pend = 1'b0;
    else        d_pend  = 1'b0;
    drive_reqs();
    bus.MEM_READY = 1'($urandom());

    @(posedge clk); #1;
    chk("resp_acks", {bus.IF_ACK, bus.D_ACK, bus.D_ERR}, 0);
  endtask

  task automatic clear_model();
    m_starve   = 0;
    m_if_rdata = 32'd0;
    m_d_rdata  = 32'd0;
    m_dout     = 32'd0;
    d_run      = 0;
    if_pend    = 1'b0;
    d_pend     = 1'b0;
  endtask

  initial begin
    bit exp_err;
    max_run = 0;
    if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; d_be = 4'd0; d_we = 1'b0;
    clear_model();
    drive_reqs();
    bus.MEM_DATA_IN = 32'd0;
    bus.MEM_READY   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("rst");
    chk("rst_addr", bus.MEM_ADDR, 0);
    chk("rst_rdata", bus.IF_RDATA | bus.D_RDATA | bus.MEM_DATA_OUT, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single fetch from 0x40
    if_pend = 1'b1; if_addr = 32'h40;
    do_access(0, 32'h00500093);

    // Store with three wait states
    d_pend = 1'b1; d_we = 1'b1; d_addr = 32'h104; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
    do_access(3, 32'h1234_5678);

    // Back-to-back loads, fetch idle
    d_pend = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_be = 4'hF;
    do_access(0, 32'hA5A5_0001);
    d_pend = 1'b1; d_we = 1'b0; d_addr = 32'h4; d_be = 4'hF;
    do_access(0, 32'h5A5A_0002);
    chk("loads_no_starve", d_run, 0);

    // Misaligned word load
    d_pend = 1'b1; d_we = 1'b0; d_addr = 32'h102; d_be = 4'hF;
`ifdef MISALIGN_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    grant_q.delete();
    do_access(0, 32'hCAFE_F00D);
    chk("misalign_err_path", grant_q.size(), 1);
    if (!exp_err) chk("misalign_issued_rdata", bus.D_RDATA, 32'hCAFE_F00D);

    // Both requesters held continuously: D,D,D,D,IF repeating
    grant_q.delete();
    new_fetch();
    new_data(1'b0);
    for (int i = 0; i < 10; i++) begin
      do_access($urandom_range(0, 1), $urandom());
      if (!if_pend) new_fetch();
      if (!d_pend) new_data(1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("starve_order_%0d", i), grant_q[i], (i % (STARVE_MAX + 1)) == STARVE_MAX);
    end
    if_pend = 1'b0; d_pend = 1'b0;
    drive_reqs();
    @(posedge clk); #1;
    chk_idle_outputs("drain");

    // Reset in the middle of a BUSY_D load
    d_pend = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF;
    drive_reqs();
    bus.MEM_READY = 1'b0;
    @(posedge clk); #1;
    chk("busy_d_re", bus.MEM_READ_ENABLE, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    chk("async_rst_addr", bus.MEM_ADDR, 0);
    chk("async_rst_data", bus.D_RDATA | bus.IF_RDATA | bus.MEM_DATA_OUT, 0);
    clear_model();
    drive_reqs();
    bus.MEM_READY = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk_idle_outputs("post_rst");
    end
    if_pend = 1'b1; if_addr = 32'h80;
    do_access(0, 32'h0000_0013);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      if (!if_pend && ($urandom_range(0, 3) != 0)) new_fetch();
      if (!d_pend && ($urandom_range(0, 3) != 0)) new_data(1'b1);
      do_access($urandom_range(0, 2), $urandom());
    end
    chk("fetch_wait_bound", (max_run <= STARVE_MAX), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-master arbiter sharing the single unified RAM port between the instruction-fetch path and the load/store path of the RISC-V core. It sequences each access as a request/acknowledge transaction, drives the memory strobes, and returns read data to the winning requester. The load/store path has fixed priority, and a starvation counter guarantees fetch forward progress. It sits between core (INSTR_ADDR/INSTR_DATA and DATA_* buses) and RAM.

Parameters:
STARVE_MAX, 4, consecutive data grants allowed while fetch waits before fetch is forced to win; legal range 1..15.
ADDR_W, 32, address width.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
IF_REQ  input  1  fetch request, held until IF_ACK
IF_ADDR  input  ADDR_W  fetch address, stable while IF_REQ
IF_RDATA  output  32  fetched instruction word
IF_ACK  output  1  one-cycle completion pulse for fetch
D_REQ  input  1  load/store request, held until D_ACK
D_WE  input  1  1 = store, 0 = load
D_ADDR  input  ADDR_W  effective address
D_WDATA  input  32  store data
D_BE  input  4  byte enables
D_RDATA  output  32  load data
D_ACK  output  1  one-cycle completion pulse for load/store
D_ERR  output  1  misaligned-access flag, valid with D_ACK
MEM_ADDR  output  ADDR_W  RAM address
MEM_DATA_OUT  output  32  RAM write data
MEM_DATA_IN  input  32  RAM read data, valid when MEM_READY
MEM_BYTE_ENABLE  output  4  RAM byte enables
MEM_WRITE_ENABLE  output  1  RAM write strobe
MEM_READ_ENABLE  output  1  RAM read strobe
MEM_READY  input  1  RAM completes current access this cycle

Behaviour:
- Clock clk; reset rst_n is asynchronous, active-low. While rst_n=0: state IDLE, all outputs 0, starve_cnt=0.
- FSM states: IDLE, BUSY_IF, BUSY_D, RESP.
- IDLE: arbitrate on sampled requests.
  - D_REQ only -> BUSY_D. IF_REQ only -> BUSY_IF.
  - Both: BUSY_IF if starve_cnt==STARVE_MAX, else BUSY_D.
  - Neither -> stay IDLE.
- Grant edge registers the MEM_* outputs. BUSY_IF: MEM_ADDR=IF_ADDR, MEM_BYTE_ENABLE=4'b1111, MEM_READ_ENABLE=1, MEM_WRITE_ENABLE=0. BUSY_D: MEM_ADDR=D_ADDR, MEM_DATA_OUT=D_WDATA, MEM_BYTE_ENABLE=D_BE, MEM_WRITE_ENABLE=D_WE, MEM_READ_ENABLE=!D_WE.
- BUSY_x: strobes held stable until MEM_READY=1 sampled. No timeout; waits indefinitely.
- On that edge:
  - Strobes and byte enables are cleared to 0.
  - For a read, MEM_DATA_IN is captured into IF_RDATA or D_RDATA; the other RDATA holds its value, and D_RDATA holds on stores.
  - The matching ACK goes high for exactly one cycle, and state -> RESP.
- RESP: ACK deasserts, and the FSM returns to IDLE with no arbitration this cycle. This lets the requester drop REQ and prevents double issue.
- Latency with zero-wait RAM (MEM_READY tied 1): REQ seen at edge 0, strobes valid after edge 0, ACK high after edge 1, IDLE after edge 2. Throughput is one access per 3 cycles.
- starve_cnt is saturating, 4 bits.
  - +1 on each D grant made while IF_REQ=1.
  - Cleared on each IF grant.
  - Unchanged on a D grant with IF_REQ=0.
- RDATA outputs are registered and hold between transactions. MEM_DATA_OUT holds the last store data.
- A REQ deasserted before ACK is a protocol violation. A transaction already in BUSY completes regardless.
- Reset mid-BUSY: strobes drop immediately (async), no ACK is issued, and the transaction is lost.
- D_ERR=0 except as stated under Optional Feature.

Optional Feature:
MISALIGN_CHECK_EN.
- Defined: at a D grant in IDLE, the access is legal only for these patterns:
  - D_BE=4'b0001<<D_ADDR[1:0] (byte).
  - D_BE=4'b0011<<D_ADDR[1:0] with D_ADDR[0]=0 (half).
  - D_BE=4'b1111 with D_ADDR[1:0]=0 (word).
- An illegal access goes straight to RESP with no MEM strobes. D_ACK=1 and D_ERR=1 are asserted together for one cycle. D_RDATA is unchanged, and starve_cnt updates as for a normal grant. D_ERR clears in RESP.
- Undefined: D_ERR tied 0, and every access is issued unchanged.

Test Plan:
- Reset: rst_n=0 mid-BUSY_D with MEM_READ_ENABLE=1 -> all outputs 0 immediately; after release, no D_ACK and state IDLE.
- Single fetch, MEM_READY=1, MEM_DATA_IN=32'h00500093, IF_ADDR=32'h40 -> MEM_ADDR=32'h40 and BE=1111 after edge 0; IF_ACK pulse after edge 1 with IF_RDATA=32'h00500093.
- Store with wait states: D_WE=1, D_ADDR=32'h104, D_WDATA=32'hDEADBEEF, D_BE=1111, MEM_READY low for 3 cycles -> strobes stable 4 cycles; one D_ACK; D_RDATA unchanged.
- Simultaneous requests held continuously, STARVE_MAX=4 -> grant order D,D,D,D,IF,D,D,D,D,IF; IF never waits more than 4 data grants.
- Back-to-back loads: D_ADDR 32'h0, 32'h4 with IF_REQ=0 -> two accesses 3 cycles apart; each D_RDATA matches its MEM_DATA_IN; starve_cnt stays 0.
- MISALIGN_CHECK_EN defined: D_ADDR=32'h102, D_BE=1111 -> no MEM strobe; D_ACK=1 and D_ERR=1 one cycle after grant. Same stimulus undefined: access issued, D_ERR=0.
